// File: rtl/sha256_sched_pkg.sv
// Shared types and constants for the SHA-256 core scheduler.
package sha256_sched_pkg;

   localparam int unsigned WORD_W       = 32;
   localparam int unsigned BLOCK_WORDS  = 16;
   localparam int unsigned DIGEST_WORDS = 8;
   localparam int unsigned DIGEST_W     = WORD_W * DIGEST_WORDS;
   localparam int unsigned CNT_W        = 4;
   localparam int unsigned DIDX_W       = 3;

   typedef logic [WORD_W-1:0]          word_t;
   typedef word_t [BLOCK_WORDS-1:0]    block_t;
   typedef logic [DIGEST_W-1:0]        digest_t;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_WAIT_BUSY = 3'd2;
   localparam logic [2:0] S_COLLECT   = 3'd3;
   localparam logic [2:0] S_RESP      = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = S_IDLE,
      ST_START     = S_START,
      ST_WAIT_BUSY = S_WAIT_BUSY,
      ST_COLLECT   = S_COLLECT,
      ST_RESP      = S_RESP
   } sched_state_t;

endpackage

// File: rtl/sha256_core_scheduler_if.sv
// Requester-side bus: level requests with blocks in, grant pulses and tagged responses out.
interface sha256_core_scheduler_if #(
   parameter int unsigned NUM_REQ = 4
) ();
   import sha256_sched_pkg::*;

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic   [NUM_REQ-1:0] req;
   block_t [NUM_REQ-1:0] blk_data;
   logic   [NUM_REQ-1:0] grant;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic   [ID_W-1:0]    rsp_id;
   digest_t              rsp_digest;
   logic                 rsp_err;

   modport master (
      output req, blk_data, rsp_ready,
      input  grant, rsp_valid, rsp_id, rsp_digest, rsp_err
   );

   modport slave (
      input  req, blk_data, rsp_ready,
      output grant, rsp_valid, rsp_id, rsp_digest, rsp_err
   );

endinterface

// File: rtl/sha256_core_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [ID_W-1:0]    pick_id,
   output logic               any
);

   logic [ID_W-1:0] idx;

   always_comb begin
      pick    = '0;
      pick_id = '0;
      any     = 1'b0;
      idx     = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx = ID_W'((32'(rr_ptr) + off) % NUM_REQ);
         if (!any && req[idx]) begin
            any     = 1'b1;
            pick_id = idx;
         end
      end
      if (any) begin
         pick[pick_id] = 1'b1;
      end
   end

endmodule

// File: rtl/sha256_core_scheduler.sv
// Shares one SHA-256 core among NUM_REQ requesters: arbitrate, load block, start,
// gather the eight digest words and return them as a tagged response.
module sha256_core_scheduler
   import sha256_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned BUSY_TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   sha256_core_scheduler_if.slave bus,
   output logic                   core_start,
   output block_t                 core_block,
   input  logic                   core_done,
   input  logic                   core_we,
   input  word_t                  core_wdata,
   output logic                   busy
);

   localparam int unsigned ID_W    = $clog2(NUM_REQ);
   localparam int unsigned TIMER_W = ($clog2(BUSY_TIMEOUT + 1) > 8) ? $clog2(BUSY_TIMEOUT + 1) : 8;
   localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(BUSY_TIMEOUT);
   localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DIGEST_WORDS);
   localparam logic [ID_W-1:0]    ID_LAST   = ID_W'(NUM_REQ - 1);

   sched_state_t             state_q, state_d;
   logic [ID_W-1:0]          id_q, id_d, rr_ptr_q, rr_ptr_d, pick_id;
   logic [NUM_REQ-1:0]       grant_q, grant_d, pick;
   logic                     start_q, start_d, req_any, timed_out;
   block_t                   block_q, block_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [TIMER_W-1:0]       timer_q, timer_d;
   logic                     err_q, err_d, valid_q, valid_d;
   word_t [DIGEST_WORDS-1:0] digest_q, digest_d;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req     (bus.req),
      .rr_ptr  (rr_ptr_q),
      .pick    (pick),
      .pick_id (pick_id),
      .any     (req_any)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         id_q     <= '0;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         start_q  <= 1'b0;
         block_q  <= '0;
         cnt_q    <= '0;
         timer_q  <= '0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         digest_q <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         start_q  <= start_d;
         block_q  <= block_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         digest_q <= digest_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = '0;
      start_d   = 1'b0;
      block_d   = block_q;
      cnt_d     = cnt_q;
      timer_d   = timer_q;
      err_d     = err_q;
      valid_d   = valid_q;
      digest_d  = digest_q;
      timed_out = (timer_q == TIMER_MAX);

      unique case (state_q)
         ST_IDLE: begin
            if (req_any && core_done) begin
               id_d     = pick_id;
               block_d  = bus.blk_data[pick_id];
               grant_d  = pick;
               start_d  = 1'b1;
               cnt_d    = '0;
               timer_d  = '0;
               err_d    = 1'b0;
               digest_d = '0;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!timed_out) timer_d = timer_q + TIMER_W'(1);
            if (!core_done) begin
               state_d = ST_COLLECT;
            end else if (timed_out) begin
               err_d   = 1'b1;
               valid_d = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_COLLECT: begin
            if (!timed_out) timer_d = timer_q + TIMER_W'(1);
            // word 0 lands in the top slot (h0); extras beyond eight are dropped as errors
            if (core_we) begin
               if (cnt_q < CNT_FULL) begin
                  digest_d[DIDX_W'(DIGEST_WORDS - 1 - 32'(cnt_q))] = core_wdata;
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            if (core_done) begin
               if (cnt_d != CNT_FULL) err_d = 1'b1;
               valid_d = 1'b1;
               state_d = ST_RESP;
            end else if (timed_out) begin
               err_d   = 1'b1;
               valid_d = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               valid_d  = 1'b0;
               rr_ptr_d = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.grant      = grant_q;
   assign bus.rsp_valid  = valid_q;
   assign bus.rsp_id     = id_q;
   assign bus.rsp_digest = digest_q;
   assign bus.rsp_err    = err_q;
   assign core_start     = start_q;
   assign core_block     = block_q;
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha256_core_scheduler.sv
// Directed bench for the scheduler with a behavioural stand-in for the hash core.
module tb_sha256_core_scheduler;
   import sha256_sched_pkg::*;

   localparam int unsigned NUM_REQ = 4;

   typedef struct {
      logic [3:0] req;
      bit         abc;
      int         nwords;
      bit         fault;
      bit         done_last;
      int         hold;
      logic [3:0] exp_grant;
      logic [1:0] exp_id;
      bit         exp_err;
   } vec_t;

   logic   clk = 1'b0;
   logic   reset;
   logic   core_start;
   block_t core_block;
   logic   core_done;
   logic   core_we;
   word_t  core_wdata;
   logic   busy;

   int     n_vec  = 0;
   int     n_fail = 0;
   int     core_nwords;
   bit     core_fault;
   bit     core_done_last;
   block_t abc_blk;
   word_t  abc_dig [8] = '{32'hba78_16bf, 32'h8f01_cfea, 32'h4141_40de, 32'h5dae_2223,
                           32'hb003_61a3, 32'h9617_7a9c, 32'hb410_ff61, 32'hf200_15ad};
   vec_t   vecs [18];

   sha256_core_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

   sha256_core_scheduler #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(255)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .core_start (core_start),
      .core_block (core_block),
      .core_done  (core_done),
      .core_we    (core_we),
      .core_wdata (core_wdata),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Stand-in core: the padded "abc" block yields the real SHA-256 digest, anything else a simple mix.
   function automatic word_t model_word(block_t b, int k);
      if (b == abc_blk && k < 8) return abc_dig[3'(k)];
      return b[4'(k)] ^ {b[4'(k + 4)][15:0], b[4'(k + 4)][31:16]} ^ 32'h0F0F_0000;
   endfunction

   function automatic digest_t exp_digest(block_t b, int n, bit fault);
      word_t [7:0] d;
      d = '0;
      if (!fault) begin
         for (int k = 0; k < n && k < 8; k++) d[3'(7 - k)] = model_word(b, k);
      end
      return d;
   endfunction

   function automatic block_t pat_blk(int r, int v);
      block_t b;
      for (int i = 0; i < 16; i++) b[4'(i)] = {8'(r + 1), 8'(v), 8'(i), 8'hC3};
      return b;
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_grant",      512'(bus.grant),      512'(0));
      check("rst_core_start", 512'(core_start),     512'(0));
      check("rst_core_block", 512'(core_block),     512'(0));
      check("rst_rsp_valid",  512'(bus.rsp_valid),  512'(0));
      check("rst_rsp_id",     512'(bus.rsp_id),     512'(0));
      check("rst_rsp_digest", 512'(bus.rsp_digest), 512'(0));
      check("rst_rsp_err",    512'(bus.rsp_err),    512'(0));
      check("rst_busy",       512'(busy),           512'(0));
   endtask

   // Core model: drops done after start, writes nwords digest words, then raises done.
   initial begin : core_model
      core_done  = 1'b1;
      core_we    = 1'b0;
      core_wdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (core_start === 1'b1 && !reset && !core_fault) begin
            @(posedge clk);
            #1 core_done = 1'b0;
            for (int k = 0; k < core_nwords; k++) begin
               @(posedge clk);
               #1;
               if (reset) break;
               core_we    = 1'b1;
               core_wdata = model_word(core_block, k);
               if (core_done_last && k == core_nwords - 1) core_done = 1'b1;
            end
            @(posedge clk);
            #1;
            core_we   = 1'b0;
            core_done = 1'b1;
         end
      end
   end

   task automatic run_vec(input vec_t v, input int row);
      block_t  eb;
      digest_t ed;
      int      t;
      eb = v.abc ? abc_blk : pat_blk(int'(v.exp_id), row);
      ed = exp_digest(eb, v.nwords, v.fault);
      for (int r = 0; r < 4; r++)
         bus.blk_data[2'(r)] = (v.abc && r == int'(v.exp_id)) ? abc_blk : pat_blk(r, row);
      core_nwords    = v.nwords;
      core_fault     = v.fault;
      core_done_last = v.done_last;
      bus.rsp_ready  = (v.hold == 0);
      bus.req        = v.req;
      t = 0;
      do begin
         @(posedge clk);
         #1 t++;
      end while (bus.grant == '0 && t < 20);
      check("grant", 512'(bus.grant), 512'(v.exp_grant));
      check("core_start", 512'(core_start), 512'(1));
      check("core_block", 512'(core_block), 512'(eb));
      bus.req = bus.req & ~v.exp_grant;
      @(posedge clk);
      #1 check("grant_pulse", 512'({bus.grant, core_start}), 512'(0));
      t = 0;
      while (!bus.rsp_valid && t < 400) begin
         @(posedge clk);
         #1 t++;
      end
      check("rsp_valid", 512'(bus.rsp_valid), 512'(1));
      if (v.fault) check("timeout_cycles", 512'(t >= 255), 512'(1));
      for (int i = 0; i < v.hold; i++) begin
         check("hold_digest", 512'(bus.rsp_digest), 512'(ed));
         check("hold_ctl", 512'({bus.rsp_valid, bus.rsp_id, core_start, busy}),
               512'({1'b1, v.exp_id, 1'b0, 1'b1}));
         @(posedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      check("rsp_id",     512'(bus.rsp_id),     512'(v.exp_id));
      check("rsp_digest", 512'(bus.rsp_digest), 512'(ed));
      check("rsp_err",    512'(bus.rsp_err),    512'(v.exp_err));
      @(posedge clk);
      #1 check("rsp_drop", 512'(bus.rsp_valid), 512'(0));
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t v;
      int   t;
      abc_blk     = '0;
      abc_blk[0]  = 32'h6162_6380;
      abc_blk[15] = 32'h0000_0018;

      //          req      abc   n  flt   dl    hold grant    id     err
      vecs[0]  = '{4'b0100, 1'b1, 8, 1'b0, 1'b0, 0,  4'b0100, 2'd2, 1'b0};
      vecs[1]  = '{4'b1000, 1'b0, 8, 1'b0, 1'b0, 0,  4'b1000, 2'd3, 1'b0};
      vecs[2]  = '{4'b1111, 1'b0, 8, 1'b0, 1'b0, 0,  4'b0001, 2'd0, 1'b0};
      vecs[3]  = '{4'b1111, 1'b0, 8, 1'b0, 1'b0, 0,  4'b0010, 2'd1, 1'b0};
      vecs[4]  = '{4'b1111, 1'b0, 8, 1'b0, 1'b0, 0,  4'b0100, 2'd2, 1'b0};
      vecs[5]  = '{4'b1111, 1'b0, 8, 1'b0, 1'b0, 0,  4'b1000, 2'd3, 1'b0};
      vecs[6]  = '{4'b1111, 1'b0, 8, 1'b0, 1'b0, 0,  4'b0001, 2'd0, 1'b0};
      vecs[7]  = '{4'b1111, 1'b0, 8, 1'b0, 1'b0, 0,  4'b0010, 2'd1, 1'b0};
      vecs[8]  = '{4'b1111, 1'b0, 8, 1'b0, 1'b0, 0,  4'b0100, 2'd2, 1'b0};
      vecs[9]  = '{4'b1111, 1'b0, 8, 1'b0, 1'b0, 0,  4'b1000, 2'd3, 1'b0};
      vecs[10] = '{4'b0110, 1'b0, 8, 1'b0, 1'b0, 0,  4'b0010, 2'd1, 1'b0};
      vecs[11] = '{4'b0011, 1'b0, 8, 1'b0, 1'b0, 0,  4'b0001, 2'd0, 1'b0};
      vecs[12] = '{4'b0010, 1'b0, 7, 1'b0, 1'b0, 0,  4'b0010, 2'd1, 1'b1};
      vecs[13] = '{4'b0100, 1'b0, 9, 1'b0, 1'b0, 0,  4'b0100, 2'd2, 1'b1};
      vecs[14] = '{4'b1000, 1'b0, 8, 1'b1, 1'b0, 0,  4'b1000, 2'd3, 1'b1};
      vecs[15] = '{4'b0001, 1'b0, 8, 1'b0, 1'b0, 0,  4'b0001, 2'd0, 1'b0};
      vecs[16] = '{4'b0100, 1'b0, 8, 1'b0, 1'b0, 20, 4'b0100, 2'd2, 1'b0};
      vecs[17] = '{4'b0001, 1'b0, 8, 1'b0, 1'b1, 0,  4'b0001, 2'd0, 1'b0};

      reset          = 1'b1;
      bus.req        = '0;
      bus.blk_data   = '0;
      bus.rsp_ready  = 1'b1;
      core_nwords    = 8;
      core_fault     = 1'b0;
      core_done_last = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_vals();
      reset = 1'b0;

      for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

      // Reset after three digest words have been captured; rr_ptr is 1 at this point.
      for (int r = 0; r < 4; r++) bus.blk_data[2'(r)] = pat_blk(r, 30);
      bus.req = 4'b1000;
      t = 0;
      do begin
         @(posedge clk);
         #1 t++;
      end while (bus.grant == '0 && t < 20);
      check("mid_grant", 512'(bus.grant), 512'(4'b1000));
      bus.req = '0;
      repeat (5) @(posedge clk);
      #1 check("mid_digest", 512'(bus.rsp_digest), 512'(exp_digest(pat_blk(3, 30), 3, 1'b0)));
      #1 reset = 1'b1;
      #1 check_reset_vals();
      @(posedge clk);
      #3 reset = 1'b0;

      // From rr_ptr 0 the pick is requester 0; a stale pointer of 1 would pick 3.
      v = '{4'b1001, 1'b0, 8, 1'b0, 1'b0, 0, 4'b0001, 2'd0, 1'b0};
      run_vec(v, 31);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/sha256_core_scheduler.md
# sha256_core_scheduler

Round-robin scheduler that shares one simplified SHA-256 core among `NUM_REQ` requesters. It arbitrates pending requests, loads the winner's 16-word block into the core, and pulses the core's start. It then collects the eight serially written digest words and returns them as one 256-bit response tagged with the requester id. It sits between the requester fabric and the single hash core instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `BUSY_TIMEOUT`, 255, maximum cycles from core start to core done returning high before an error response
- `clk` in 1: sole clock; core runs on the same clock
- `reset` in 1: asynchronous, active-high; clears all state
- `req` in `NUM_REQ`: level request per requester; held until its `grant` pulse
- `blk_data` in `NUM_REQ`×16×32: per-requester message block, word 0 first; must be stable while `req` is high
- `grant` out `NUM_REQ`: one-hot, 1-cycle pulse; the block has been sampled
- `core_start` out 1: 1-cycle start pulse to the core
- `core_block` out 16×32: registered block driven to the core's `mem_read_data`
- `core_done` in 1: core `done`; high while the core is idle
- `core_we` in 1: core `mem_we`; digest word valid this cycle
- `core_wdata` in 32: core `mem_write_data`
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: consumer accepts the response
- `rsp_id` out `$clog2(NUM_REQ)`: requester that owns the response
- `rsp_digest` out 256: h0 in bits [255:224], through h7 in bits [31:0]
- `rsp_err` out 1: response is invalid (timeout or wrong word count)
- `busy` out 1: state ≠ IDLE

## Operation
- States: IDLE, START, WAIT_BUSY, COLLECT, RESP.
- IDLE: arbitration happens only when `|req` and `core_done`=1.
  - Winner is the first requester with `req` high, searching from `rr_ptr` upward and wrapping.
  - Latch the winner's id and `blk_data[id]` into `core_block`.
  - Clear `word_cnt`, `timer`, `rsp_err` and `rsp_digest`; go to START.
- START: `grant[id]`=1 and `core_start`=1 for exactly this cycle. Go to WAIT_BUSY.
- WAIT_BUSY: wait for `core_done`=0, then go to COLLECT. If `timer` reaches `BUSY_TIMEOUT`, set `rsp_err` and go to RESP.
- COLLECT: each cycle with `core_we`=1 and `word_cnt`<8:
  - write `core_wdata` into `rsp_digest[255-32*word_cnt -: 32]`;
  - increment `word_cnt`.
- COLLECT, other `core_we` cases:
  - `core_we`=1 while `word_cnt`=8: word discarded, `rsp_err`=1.
  - `core_we`=1 in the same cycle that `core_done` rises: the word is still captured.
- COLLECT exit: when `core_done`=1, go to RESP. `rsp_err` is set if `word_cnt`≠8. Timeout applies here exactly as in WAIT_BUSY.
- RESP: hold `rsp_valid`, `rsp_id`, `rsp_digest` and `rsp_err` stable until `rsp_ready`=1.
  - On handshake: `rr_ptr` ← (id+1) mod `NUM_REQ`; go to IDLE.
- `timer`: 8-bit (width ≥ `$clog2(BUSY_TIMEOUT+1)`). Increments in WAIT_BUSY and COLLECT and saturates at the limit.
- `req` dropped before its grant: the requester simply loses eligibility. Only IDLE samples `req`.
- `core_we` outside COLLECT: ignored.

## Timing
- Reset values:
  - `grant`=0, `core_start`=0, `core_block`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_digest`=0, `rsp_err`=0.
  - `busy`=0, `rr_ptr`=0, state=IDLE.
- All outputs are registered except `busy`, which is decoded from state.
- Latency: `req` high in IDLE at edge N → `grant` and `core_start` high in cycle N+1.
- `rsp_valid` rises in the cycle after the edge where `core_done` is seen returning high.
- Handshake completes at an edge where `rsp_valid`=1 and `rsp_ready`=1. `rsp_ready` already high when `rsp_valid` rises gives a 1-cycle RESP. Earliest re-arbitration is the following cycle.
- Back-to-back requests: minimum gap between successive `core_start` pulses is RESP + IDLE = 2 cycles beyond the core's own latency.
- Reset mid-operation: immediately return to reset values. An in-flight transaction is lost and no response is produced. The core is reset separately.

## Structure
- Package `sha256_sched_pkg`:
  - `word_t` (32b), `block_t` (16×`word_t`), `digest_t` (256b);
  - `DIGEST_WORDS`=8, `BLOCK_WORDS`=16;
  - state enum `sched_state_t`.
- Sub-module `rr_arbiter`: combinational. Inputs `req`, `rr_ptr`; outputs one-hot `pick`, `pick_id`, `any`. The top holds the FSM, registers and digest assembly.

## Test plan
- Single request: `req`=4'b0100 with a block of "abc" padded → `grant`=4'b0100 for 1 cycle; `rsp_id`=2; `rsp_digest`=ba7816bf…f20015ad; `rsp_err`=0.
- Fairness: all four `req` held high over 8 transactions → grant order 0,1,2,3,0,1,2,3.
- Backpressure: `rsp_ready`=0 for 20 cycles → `rsp_valid`, `rsp_digest` and `rsp_id` stay stable; no new `core_start`.
- Core fault (model core): `core_done` never drops after start → `rsp_err`=1 after `BUSY_TIMEOUT` cycles; `rsp_valid`=1.
- Word count: model core emits 7 words, then separately 9 words → `rsp_err`=1 in both cases. With 9 words, `rsp_digest` holds the first 8.
- Reset during COLLECT: after 3 words are captured, pulse `reset` for 1 cycle → all outputs are 0 and state is IDLE. The next request is served from `rr_ptr`=0.
